simon_tone_sequencer: RTL and testbench

- Playback engine that drives the tone generator's note/enable interface, as the producer side of that interface.
- On a start pulse it walks a stored colour sequence (0..3) of programmable length.
- For each entry it outputs the colour's note period and asserts enable for a fixed tone time, then a silent gap, then advances to the next entry.
- Sits between the game controller / sequence RAM and the speaker driver, and also lights the matching LED during each tone.

---
 rtl/simon_tone_sequencer.sv | 129 ++++++++++++
 tb/tb_simon_tone_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/simon_tone_sequencer.sv
// Simon playback engine: walks a colour sequence from memory and drives the
// tone generator's note/enable pair plus the matching one-hot LED.
module simon_tone_sequencer #(
  parameter int          TONE_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 10000000,
  parameter int          ADDR_W      = 5,
  parameter logic [17:0] NOTE0       = 18'd151745,
  parameter logic [17:0] NOTE1       = 18'd180505,
  parameter logic [17:0] NOTE2       = 18'd227273,
  parameter logic [17:0] NOTE3       = 18'd113636
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] seq_addr,
  input  logic [1:0]        seq_data,
  output logic [17:0]       note,
  output logic              enable,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int TMAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] TONE_LOAD = TW'(TONE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        colour;
  logic [TW-1:0]     timer;

  function automatic logic [17:0] note_of(input logic [1:0] c);
    case (c)
      2'd0:    note_of = NOTE0;
      2'd1:    note_of = NOTE1;
      2'd2:    note_of = NOTE2;
      default: note_of = NOTE3;
    endcase
  endfunction

  // LED is a pure function of registered state, so no input reaches it combinationally.
  assign led = enable ? (4'b0001 << colour) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      seq_addr <= '0;
      idx      <= '0;
      len      <= '0;
      colour   <= '0;
      timer    <= '0;
      note     <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort && state != IDLE) begin
      state    <= IDLE;
      seq_addr <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          seq_addr <= '0;
          done     <= 1'b0;
          if (start && !abort) begin
            busy <= 1'b1;
            if (seq_len != '0) begin
              len    <= seq_len;
              colour <= seq_data;
              note   <= note_of(seq_data);
              idx    <= '0;
              timer  <= TONE_LOAD;
              enable <= 1'b1;
              state  <= TONE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        TONE: begin
          if (timer == '0) begin
            // Prefetch the next entry's address; it wraps harmlessly after the last one.
            seq_addr <= idx + ADDR_W'(1);
            timer    <= GAP_LOAD;
            enable   <= 1'b0;
            state    <= GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (timer == '0) begin
            if ({1'b0, idx} == len - (ADDR_W+1)'(1)) begin
              seq_addr <= '0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              idx    <= idx + ADDR_W'(1);
              colour <= seq_data;
              note   <= note_of(seq_data);
              timer  <= TONE_LOAD;
              enable <= 1'b1;
              state  <= TONE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          seq_addr <= '0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_tone_sequencer.sv
// Bench for simon_tone_sequencer: directed and randomized playbacks checked
// cycle by cycle against a timeline model derived from tone/gap arithmetic.
module tb_simon_tone_sequencer;

  localparam int T  = 4;
  localparam int G  = 2;
  localparam int AW = 5;
  localparam int P  = T + G;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW:0]   seq_len;
  logic [AW-1:0] seq_addr;
  logic [1:0]    seq_data;
  logic [17:0]   note;
  logic          enable;
  logic [3:0]    led;
  logic          busy;
  logic          done;

  logic [1:0]  mem [32];
  logic [17:0] note_tab [4];
  logic [17:0] last_note;
  int          n_assert = 0;
  int          n_fail   = 0;

  assign seq_data = mem[seq_addr];

  simon_tone_sequencer #(
    .TONE_CYCLES(T), .GAP_CYCLES(G), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_len(seq_len),
    .seq_addr(seq_addr), .seq_data(seq_data), .note(note), .enable(enable),
    .led(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [17:0] exp_note);
    check({tag, "_enable"}, 32'(enable), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_addr"}, 32'(seq_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_note"}, 32'(note), 32'(exp_note));
  endtask

  // Plays len entries; optionally scrambles start/seq_len/memory mid-run, or
  // cuts the run with abort (cut_rst=0) or reset (cut_rst=1) after sample cut_at.
  task automatic play(input int len, input bit perturb, input int cut_at, input bit cut_rst);
    logic [1:0]  col [$];
    logic [17:0] exp_note;
    logic [3:0]  exp_led;
    int          last;
    last = len * P;
    col = {};
    for (int i = 0; i < len; i++) col.push_back(mem[i]);
    @(negedge clk);
    start   = 1'b1;
    seq_len = (AW+1)'(len);
    @(posedge clk);
    #1;
    for (int s = 0; s <= last + 1; s++) begin
      int e, ph;
      bit in_play, exp_en;
      e       = s / P;
      ph      = s % P;
      in_play = s < last;
      exp_en  = in_play && ph < T;
      exp_led = exp_en ? (4'b0001 << col[e]) : 4'b0000;
      if (len == 0) exp_note = last_note;
      else exp_note = note_tab[col[(e < len) ? e : len - 1]];
      check("enable", 32'(enable), 32'(exp_en));
      check("led", 32'(led), 32'(exp_led));
      check("note", 32'(note), 32'(exp_note));
      check("seq_addr", 32'(seq_addr), !in_play ? 32'd0 : (ph < T ? 32'(e) : 32'((e + 1) % 32)));
      check("busy", 32'(busy), 32'(s <= last));
      check("done", 32'(done), 32'(s == last));
      if (s == cut_at) begin
        @(negedge clk);
        if (cut_rst) rst_n = 1'b0;
        else abort = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        last_note = cut_rst ? 18'd0 : exp_note;
        check_idle(cut_rst ? "rst_cut" : "abort_cut", last_note);
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          check("post_cut_busy", 32'(busy), 32'd0);
          check("post_cut_done", 32'(done), 32'd0);
        end
        return;
      end
      @(negedge clk);
      start = 1'b0;
      if (perturb && s <= last) begin
        start   = 1'($urandom_range(0, 1));
        seq_len = (AW+1)'($urandom);
        if (exp_en) mem[e] = 2'($urandom);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (len > 0) last_note = note_tab[col[len - 1]];
  endtask

  initial begin
    note_tab[0] = 18'd151745;
    note_tab[1] = 18'd180505;
    note_tab[2] = 18'd227273;
    note_tab[3] = 18'd113636;
    for (int i = 0; i < 32; i++) mem[i] = 2'd0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seq_len = '0;
    repeat (3) @(posedge clk);
    #1;
    last_note = 18'd0;
    check_idle("reset", 18'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Canonical three-note sequence.
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    play(3, 1'b0, -1, 1'b0);

    // Zero length: done the cycle after start, no tone.
    play(0, 1'b0, -1, 1'b0);

    // Full-length sequence covering every address.
    for (int i = 0; i < 32; i++) mem[i] = 2'(i % 4);
    play(32, 1'b0, -1, 1'b0);

    // Abort in the second tone, then replay from entry 0.
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
    play(3, 1'b0, P + 1, 1'b0);
    play(3, 1'b0, -1, 1'b0);

    // Abort together with start in IDLE must not launch playback.
    @(negedge clk);
    abort = 1'b1; start = 1'b1; seq_len = 6'd3;
    @(posedge clk);
    #1;
    check("abort_start_busy", 32'(busy), 32'd0);
    check("abort_start_enable", 32'(enable), 32'd0);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_start_busy2", 32'(busy), 32'd0);
    check("abort_start_done", 32'(done), 32'd0);

    // Start/seq_len/memory noise during playback.
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
    play(4, 1'b1, -1, 1'b0);

    // Reset in the middle of the first tone, then a normal run.
    play(3, 1'b0, 2, 1'b1);
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
    play(2, 1'b0, -1, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 2'($urandom);
      play($urandom_range(1, 10), 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
